wb_rr_arbiter: RTL and testbench

WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

---
 rtl/wb_rr_arbiter.sv | 145 ++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: N_INIT initiators share one target bus.
// It also has a stb-to-ack watchdog that aborts a stalled cycle and masks its initiator.
module wb_rr_arbiter #(
   parameter int N_INIT     = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [N_INIT-1:0]                i_cyc,
   input  logic [N_INIT-1:0]                i_stb,
   input  logic [N_INIT-1:0]                i_we,
   input  logic [N_INIT*ADDR_WIDTH-1:0]     i_adr,
   input  logic [N_INIT*DATA_WIDTH-1:0]     i_dat_w,
   input  logic [N_INIT*DATA_WIDTH/8-1:0]   i_sel,
   output logic [N_INIT-1:0]                i_ack,
   output logic [N_INIT-1:0]                i_err,
   output logic [DATA_WIDTH-1:0]            i_dat_r,
   output logic                             t_cyc,
   output logic                             t_stb,
   output logic                             t_we,
   output logic [ADDR_WIDTH-1:0]            t_adr,
   output logic [DATA_WIDTH-1:0]            t_dat_w,
   output logic [DATA_WIDTH/8-1:0]          t_sel,
   input  logic                             t_ack,
   input  logic [DATA_WIDTH-1:0]            t_dat_r,
   output logic [N_INIT-1:0]                gnt
);

   localparam int SW = DATA_WIDTH / 8;
   localparam int IW = (N_INIT > 1) ? $clog2(N_INIT) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

   state_t              state_q, state_d;
   logic [N_INIT-1:0]   gnt_q, gnt_d;
   logic [IW-1:0]       gidx_q, gidx_d;
   logic [IW-1:0]       last_q, last_d;
   logic [7:0]          wait_q, wait_d;
   logic [N_INIT-1:0]   mask_q, mask_d;

   logic [N_INIT-1:0]   elig;
   logic                found;
   logic [IW-1:0]       pick;
   logic [IW-1:0]       cand;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         gidx_q  <= '0;
         last_q  <= IW'(N_INIT - 1);
         wait_q  <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         gidx_q  <= gidx_d;
         last_q  <= last_d;
         wait_q  <= wait_d;
         mask_q  <= mask_d;
      end
   end

   // Rotating priority: first eligible requester after the last one served.
   always_comb begin
      elig  = i_cyc & ~mask_q;
      found = 1'b0;
      pick  = last_q;
      cand  = '0;
      for (int i = 1; i <= N_INIT; i++) begin
         cand = IW'((int'(last_q) + i) % N_INIT);
         if (!found && elig[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      gidx_d  = gidx_q;
      last_d  = last_q;
      wait_d  = '0;
      mask_d  = mask_q & i_cyc;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d     = BUSY;
               gidx_d      = pick;
               gnt_d       = '0;
               gnt_d[pick] = 1'b1;
            end
         end
         BUSY: begin
            if (!i_cyc[gidx_q]) begin
               state_d = IDLE;
               last_d  = gidx_q;
               gnt_d   = '0;
            end else if (i_stb[gidx_q] && !t_ack) begin
               // An ack on the terminal-count cycle never reaches this branch, so it wins.
               if (wait_q == 8'(TIMEOUT - 1)) state_d = ABORT;
               else                           wait_d  = wait_q + 8'd1;
            end
         end
         ABORT: begin
            state_d        = IDLE;
            last_d         = gidx_q;
            gnt_d          = '0;
            mask_d[gidx_q] = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      t_cyc   = 1'b0;
      t_stb   = 1'b0;
      t_we    = 1'b0;
      t_adr   = '0;
      t_dat_w = '0;
      t_sel   = '0;
      i_ack   = '0;
      i_err   = '0;
      case (state_q)
         BUSY: begin
            t_cyc         = i_cyc[gidx_q];
            t_stb         = i_stb[gidx_q];
            t_we          = i_we[gidx_q];
            t_adr         = i_adr[int'(gidx_q)*ADDR_WIDTH +: ADDR_WIDTH];
            t_dat_w       = i_dat_w[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];
            t_sel         = i_sel[int'(gidx_q)*SW +: SW];
            i_ack[gidx_q] = t_ack;
         end
         ABORT:   i_err = gnt_q;
         default: ;
      endcase
   end

   assign gnt     = gnt_q;
   assign i_dat_r = t_dat_r;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter (4 initiators, 32-bit bus, TIMEOUT=16).
module tb_wb_rr_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic            clock = 1'b0;
   logic            reset;
   logic [N-1:0]    i_cyc, i_stb, i_we;
   logic [N*AW-1:0] i_adr;
   logic [N*DW-1:0] i_dat_w;
   logic [N*4-1:0]  i_sel;
   logic [N-1:0]    i_ack, i_err, gnt;
   logic [DW-1:0]   i_dat_r;
   logic            t_cyc, t_stb, t_we, t_ack;
   logic [AW-1:0]   t_adr;
   logic [DW-1:0]   t_dat_w, t_dat_r;
   logic [3:0]      t_sel;

   int testCount = 0;
   int failCount = 0;
   logic [N-1:0] expGnt;
   logic [DW-1:0] memWord;

   wb_rr_arbiter #(.N_INIT(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(16)) dut (
      .clock(clock), .reset(reset),
      .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we),
      .i_adr(i_adr), .i_dat_w(i_dat_w), .i_sel(i_sel),
      .i_ack(i_ack), .i_err(i_err), .i_dat_r(i_dat_r),
      .t_cyc(t_cyc), .t_stb(t_stb), .t_we(t_we),
      .t_adr(t_adr), .t_dat_w(t_dat_w), .t_sel(t_sel),
      .t_ack(t_ack), .t_dat_r(t_dat_r), .gnt(gnt)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [N-1:0] cyc, input logic [N-1:0] stb,
                                input logic [N-1:0] we, input logic ack);
      i_cyc = cyc;
      i_stb = stb;
      i_we  = we;
      t_ack = ack;
      #1;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic doReset();
      reset = 1'b1;
      applyStimulus('0, '0, '0, 1'b0);
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset   = 1'b1;
      i_adr   = '0;
      i_dat_w = '0;
      i_sel   = '0;
      t_dat_r = '0;
      memWord = '0;
      doReset();
      checkOutput("reset_gnt", 32'(gnt), 32'h0);
      checkOutput("reset_tcyc", 32'(t_cyc), 32'h0);
      checkOutput("reset_ack_err", 32'({i_ack, i_err}), 32'h0);

      // Simultaneous requests at reset release: initiator 0 first, then 2.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      applyStimulus(4'b0101, 4'b0000, 4'b0000, 1'b0);
      tick();
      checkOutput("rel_gnt0", 32'(gnt), 32'h1);
      checkOutput("rel_tcyc", 32'(t_cyc), 32'h1);
      applyStimulus(4'b0100, 4'b0000, 4'b0000, 1'b0);
      tick();
      checkOutput("rel_idle_gap", 32'(gnt), 32'h0);
      tick();
      checkOutput("rel_gnt2", 32'(gnt), 32'h4);
      applyStimulus('0, '0, '0, 1'b0);
      tick();

      // Fair rotation with every initiator requesting single acked transfers.
      doReset();
      expGnt = 4'b0001;
      applyStimulus(4'b1111, 4'b1111, 4'b0000, 1'b1);
      for (int k = 0; k < 5; k++) begin
         tick();
         checkOutput($sformatf("rot_gnt_%0d", k), 32'(gnt), 32'(expGnt));
         checkOutput($sformatf("rot_ack_%0d", k), 32'(i_ack), 32'(expGnt));
         applyStimulus(4'b1111 & ~expGnt, 4'b1111, 4'b0000, 1'b1);
         tick();
         checkOutput($sformatf("rot_gap_%0d", k), 32'(gnt), 32'h0);
         applyStimulus(4'b1111, 4'b1111, 4'b0000, 1'b1);
         expGnt = {expGnt[N-2:0], expGnt[N-1]};
      end

      // Initiator 1 write then immediate read-back through a one-word target.
      doReset();
      i_adr[1*AW +: AW]   = 32'h100;
      i_dat_w[1*DW +: DW] = 32'hDEADBEEF;
      i_sel[1*4 +: 4]     = 4'hF;
      applyStimulus(4'b0010, 4'b0010, 4'b0010, 1'b0);
      tick();
      checkOutput("wr_gnt", 32'(gnt), 32'h2);
      checkOutput("wr_adr", t_adr, 32'h100);
      checkOutput("wr_dat", t_dat_w, 32'hDEADBEEF);
      checkOutput("wr_we_sel", 32'({t_we, t_sel}), 32'h1F);
      applyStimulus(4'b0010, 4'b0010, 4'b0010, 1'b1);
      checkOutput("wr_ack", 32'(i_ack), 32'h2);
      if (t_cyc && t_stb && t_we && t_adr == 32'h100) memWord = t_dat_w;
      tick();
      t_dat_r = memWord;
      applyStimulus(4'b0010, 4'b0010, 4'b0000, 1'b1);
      checkOutput("rd_gnt", 32'(gnt), 32'h2);
      checkOutput("rd_we", 32'(t_we), 32'h0);
      checkOutput("rd_dat", i_dat_r, 32'hDEADBEEF);
      checkOutput("rd_ack", 32'(i_ack), 32'h2);
      tick();
      applyStimulus('0, '0, '0, 1'b0);
      tick();
      checkOutput("rd_release", 32'(gnt), 32'h0);

      // Target never acks: abort after 16 cycles, then initiator 2 is masked.
      doReset();
      applyStimulus(4'b0100, 4'b0100, 4'b0000, 1'b0);
      tick();
      checkOutput("to_gnt", 32'(gnt), 32'h4);
      for (int k = 1; k < 16; k++) begin
         tick();
         checkOutput($sformatf("to_wait_%0d", k), 32'({t_cyc, i_err}), 32'h10);
      end
      tick();
      checkOutput("to_err", 32'(i_err), 32'h4);
      checkOutput("to_bus_low", 32'({t_cyc, t_stb}), 32'h0);
      checkOutput("to_gnt_held", 32'(gnt), 32'h4);
      tick();
      checkOutput("to_err_once", 32'(i_err), 32'h0);
      checkOutput("to_gnt_clear", 32'(gnt), 32'h0);
      tick();
      checkOutput("to_masked", 32'(gnt), 32'h0);
      applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0);
      tick();
      applyStimulus(4'b0100, 4'b0100, 4'b0000, 1'b0);
      tick();
      checkOutput("to_regrant", 32'(gnt), 32'h4);
      applyStimulus('0, '0, '0, 1'b0);
      tick();

      // Ack on the terminal-count cycle wins over the timeout.
      doReset();
      applyStimulus(4'b0001, 4'b0001, 4'b0000, 1'b0);
      tick();
      for (int k = 1; k < 16; k++) tick();
      applyStimulus(4'b0001, 4'b0001, 4'b0000, 1'b1);
      checkOutput("late_ack", 32'(i_ack), 32'h1);
      tick();
      applyStimulus(4'b0001, 4'b0001, 4'b0000, 1'b0);
      checkOutput("late_no_err", 32'(i_err), 32'h0);
      checkOutput("late_busy", 32'({gnt, t_cyc}), 32'h3);
      applyStimulus('0, '0, '0, 1'b0);
      tick();

      // One-cycle reset in the middle of a cycle drops the grant silently.
      doReset();
      applyStimulus(4'b1000, 4'b1000, 4'b0000, 1'b0);
      tick();
      checkOutput("rst_busy_gnt", 32'(gnt), 32'h8);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("rst_gnt_drop", 32'(gnt), 32'h0);
      checkOutput("rst_tcyc_drop", 32'(t_cyc), 32'h0);
      checkOutput("rst_no_err", 32'(i_err), 32'h0);
      applyStimulus('0, '0, '0, 1'b0);
      tick();

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

   // Any i_err outside the abort scenario would be caught by the directed checks above;
   // this guard keeps the run bounded regardless of stimulus mistakes.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
